// File: rtl/control_sequencer.sv
// Hardwired control sequencer: a fetch/execute FSM (RST, T0-T7, HALT) with a
// Moore decode of state and IR opcode onto the datapath control lines.
module control_sequencer #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout,
  output logic        PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, read, write,
  output logic        Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout,
  output logic        R8_RAin, InPortout, Out_portIn, conIn,
  output logic [4:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  state_e     state_q, state_d, last_st;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];

  // Final execute step per opcode; reaching it returns to T0.
  always_comb begin
    last_st = S_T3;
    case (op) inside
      [5'h00:5'h0E]: last_st = S_T5;
      5'h0F, 5'h10:  last_st = S_T6;
      5'h11, 5'h12:  last_st = S_T4;
      5'h13, 5'h15:  last_st = S_T7;
      5'h14:         last_st = S_T5;
      5'h16:         last_st = S_T6;
      5'h18:         last_st = S_T4;
      default:       last_st = S_T3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        case (op)
          5'h1D:   state_d = S_T0;
          5'h1E:   state_d = S_HALT;
          5'h1F:   state_d = ILLEGAL_HALT ? S_HALT : S_T0;
          default: state_d = S_T3;
        endcase
      end
      S_T3:   state_d = (last_st == S_T3) ? S_T0 : S_T4;
      S_T4:   state_d = (last_st == S_T4) ? S_T0 : S_T5;
      S_T5:   state_d = (last_st == S_T5) ? S_T0 : S_T6;
      S_T6:   state_d = (last_st == S_T6) ? S_T0 : S_T7;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_RST;
    else        state_q <= state_d;
  end

  assign run = (state_q != S_RST) && (state_q != S_HALT);

  // Control decode is combinational on state so clear kills write at once.
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout}                          = '0;
    {PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, read, write}    = '0;
    {Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout}          = '0;
    {R8_RAin, InPortout, Out_portIn, conIn}                          = '0;
    alu_op = 5'h00;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (op) inside
          [5'h00:5'h0E]: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          5'h0F, 5'h10:  begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          5'h11, 5'h12:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
          [5'h13:5'h15]: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          5'h16:         begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
          5'h17:         begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          5'h18:         begin PCout = 1'b1; R8_RAin = 1'b1; end
          5'h19:         begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          5'h1A:         begin Gra = 1'b1; Rout = 1'b1; Out_portIn = 1'b1; end
          5'h1B:         begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          5'h1C:         begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op) inside
          [5'h00:5'h0B]: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
          5'h0C:         begin Cout = 1'b1; Zin = 1'b1; alu_op = 5'h00; end
          5'h0D:         begin Cout = 1'b1; Zin = 1'b1; alu_op = 5'h02; end
          5'h0E:         begin Cout = 1'b1; Zin = 1'b1; alu_op = 5'h03; end
          5'h0F, 5'h10:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
          5'h11, 5'h12:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          [5'h13:5'h15]: begin Cout = 1'b1; Zin = 1'b1; end
          5'h16:         begin PCout = 1'b1; Yin = 1'b1; end
          5'h18:         begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op) inside
          [5'h00:5'h0E], 5'h14: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          5'h0F, 5'h10:  begin Zlowout = 1'b1; LOin = 1'b1; end
          5'h13, 5'h15:  begin Zlowout = 1'b1; MARin = 1'b1; end
          5'h16:         begin Cout = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op)
          5'h0F, 5'h10: begin Zhighout = 1'b1; HIin = 1'b1; end
          5'h13:        begin read = 1'b1; MDRin = 1'b1; end
          5'h15:        begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          5'h16:        begin Zlowout = 1'b1; PCin = con; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op)
          5'h13:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          5'h15:   write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks instructions state by state and
// compares the packed control word against hand-built expectations.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir    = '0;
  logic        con   = 1'b0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, read, write;
  logic Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout;
  logic R8_RAin, InPortout, Out_portIn, conIn, run;
  logic [4:0] alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  control_sequencer #(.ILLEGAL_HALT(1'b1)) dut (
    .clock(clock), .clear(clear), .ir(ir), .con(con),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .read(read), .write(write),
    .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .R8_RAin(R8_RAin), .InPortout(InPortout), .Out_portIn(Out_portIn), .conIn(conIn),
    .alu_op(alu_op), .run(run)
  );

  localparam logic [27:0] GRA = 28'd1 << 0,  GRB = 28'd1 << 1,  GRC = 28'd1 << 2,
    RIN = 28'd1 << 3,  ROUT = 28'd1 << 4,  BAOUT = 28'd1 << 5, COUT = 28'd1 << 6,
    PCOUT = 28'd1 << 7, PCIN = 28'd1 << 8, INCPC = 28'd1 << 9, IRIN = 28'd1 << 10,
    MARIN = 28'd1 << 11, MDRIN = 28'd1 << 12, MDROUT = 28'd1 << 13, READ = 28'd1 << 14,
    WRITE = 28'd1 << 15, YIN = 28'd1 << 16, ZIN = 28'd1 << 17, ZHI = 28'd1 << 18,
    ZLO = 28'd1 << 19, HIIN = 28'd1 << 20, HIOUT = 28'd1 << 21, LOIN = 28'd1 << 22,
    LOOUT = 28'd1 << 23, R8 = 28'd1 << 24, INP = 28'd1 << 25, OUTP = 28'd1 << 26,
    CONIN = 28'd1 << 27;

  logic [33:0] obs;
  assign obs = {run, alu_op, conIn, Out_portIn, InPortout, R8_RAin, LOout, LOin, HIout,
                HIin, Zlowout, Zhighout, Zin, Yin, write, read, MDRout, MDRin, MARin,
                IRin, IncPC, PCin, PCout, Cout, BAout, Rout, Rin, Grc, Grb, Gra};

  function automatic logic [33:0] v(input logic r, input logic [4:0] a, input logic [27:0] m);
    return {r, a, m};
  endfunction

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Check the present state, then advance one clock.
  task automatic sc(input string tag, input logic [33:0] exp);
    chk(tag, obs, exp);
    step();
  endtask

  task automatic fetch(input string tag);
    sc({tag, "_T0"}, v(1'b1, 5'h00, PCOUT | MARIN | INCPC));
    sc({tag, "_T1"}, v(1'b1, 5'h00, READ | MDRIN));
    sc({tag, "_T2"}, v(1'b1, 5'h00, MDROUT | IRIN));
  endtask

  task automatic do_reset(input string tag);
    clear = 1'b0;
    repeat (3) step();
    chk({tag, "_hold"}, obs, '0);
    clear = 1'b1;
    chk({tag, "_c1"}, obs, '0);
    step();
  endtask

  initial begin
    do_reset("rst");

    ir = 32'h0091_8000;  // add
    fetch("add");
    sc("add_T3", v(1, 5'h00, GRB | ROUT | YIN));
    sc("add_T4", v(1, 5'h00, GRC | ROUT | ZIN));
    sc("add_T5", v(1, 5'h00, ZLO | GRA | RIN));

    ir = {5'h0E, 27'd0};  // ori
    fetch("ori");
    sc("ori_T3", v(1, 5'h00, GRB | ROUT | YIN));
    sc("ori_T4", v(1, 5'h03, COUT | ZIN));
    sc("ori_T5", v(1, 5'h00, ZLO | GRA | RIN));

    ir = {5'h0F, 27'd0};  // mul
    fetch("mul");
    sc("mul_T3", v(1, 5'h00, GRA | ROUT | YIN));
    sc("mul_T4", v(1, 5'h0F, GRB | ROUT | ZIN));
    sc("mul_T5", v(1, 5'h00, ZLO | LOIN));
    sc("mul_T6", v(1, 5'h00, ZHI | HIIN));

    ir = {5'h11, 27'd0};  // neg
    fetch("neg");
    sc("neg_T3", v(1, 5'h11, GRB | ROUT | ZIN));
    sc("neg_T4", v(1, 5'h00, ZLO | GRA | RIN));

    ir = {5'h13, 27'd0};  // ld
    fetch("ld");
    sc("ld_T3", v(1, 5'h00, GRB | BAOUT | YIN));
    sc("ld_T4", v(1, 5'h00, COUT | ZIN));
    sc("ld_T5", v(1, 5'h00, ZLO | MARIN));
    sc("ld_T6", v(1, 5'h00, READ | MDRIN));
    sc("ld_T7", v(1, 5'h00, MDROUT | GRA | RIN));

    ir = {5'h16, 27'd0}; con = 1'b1;  // br taken
    fetch("brt");
    sc("brt_T3", v(1, 5'h00, GRA | ROUT | CONIN));
    sc("brt_T4", v(1, 5'h00, PCOUT | YIN));
    sc("brt_T5", v(1, 5'h00, COUT | ZIN));
    sc("brt_T6", v(1, 5'h00, ZLO | PCIN));

    con = 1'b0;  // br not taken still spends T6
    fetch("brn");
    sc("brn_T3", v(1, 5'h00, GRA | ROUT | CONIN));
    sc("brn_T4", v(1, 5'h00, PCOUT | YIN));
    sc("brn_T5", v(1, 5'h00, COUT | ZIN));
    sc("brn_T6", v(1, 5'h00, ZLO));

    ir = {5'h1B, 27'd0};  // mfhi
    fetch("mfhi");
    sc("mfhi_T3", v(1, 5'h00, HIOUT | GRA | RIN));

    ir = {5'h1D, 27'd0};  // nop
    fetch("nop");

    ir = {5'h18, 27'd0};  // jal
    fetch("jal");
    sc("jal_T3", v(1, 5'h00, PCOUT | R8));
    sc("jal_T4", v(1, 5'h00, GRA | ROUT | PCIN));

    ir = {5'h1E, 27'd0};  // halt
    fetch("halt");
    for (int i = 0; i < 20; i++) sc($sformatf("halt_c%0d", i), '0);

    do_reset("rst2");
    ir = {5'h1F, 27'd0};  // illegal opcode halts
    fetch("ill");
    sc("ill_halt0", '0);
    sc("ill_halt1", '0);

    do_reset("rst3");
    ir = {5'h15, 27'd0};  // st, reset in T7
    fetch("st");
    sc("st_T3", v(1, 5'h00, GRB | BAOUT | YIN));
    sc("st_T4", v(1, 5'h00, COUT | ZIN));
    sc("st_T5", v(1, 5'h00, ZLO | MARIN));
    sc("st_T6", v(1, 5'h00, GRA | ROUT | MDRIN));
    chk("st_T7", obs, v(1, 5'h00, WRITE));
    #2 clear = 1'b0;
    #1 chk("st_async_clr", obs, '0);
    step();
    chk("st_clr_held", obs, '0);
    clear = 1'b1;
    step();
    ir = {5'h1D, 27'd0};
    fetch("refetch");
    chk("refetch_T0", obs, v(1'b1, 5'h00, PCOUT | MARIN | INCPC));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter ILLEGAL_HALT, default 1: opcode 5'h1F enters HALT when 1 and acts as nop when 0.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 clear  input  1  asynchronous, active-low reset.
REQ-004 ir  input  32  current IR contents; opcode = ir[31:27].
REQ-005 con  input  1  latched branch condition from the CON flip-flop.
REQ-006 Gra, Grb, Grc, Rin, Rout, BAout, Cout  output  1 each  select-encode and constant controls.
REQ-007 PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, read, write  output  1 each  fetch and memory controls.
REQ-008 Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout  output  1 each  ALU-side controls.
REQ-009 R8_RAin, InPortout, Out_portIn, conIn  output  1 each  link, I/O and CON-latch controls.
REQ-010 alu_op  output  5  ALU operation code.
REQ-011 run  output  1  high while the sequencer executes; low in RST and HALT.

Function
REQ-012 The state register SHALL be a single registered FSM, and all outputs SHALL be a pure (Moore) decode of the state plus ir.
REQ-013 Each state SHALL last exactly one cycle, and every control not listed for a state SHALL be 0.
REQ-014 alu_op SHALL be 5'h00 in any state where Zin=0.
REQ-015 The state set SHALL be RST, T0-T7 and HALT.
REQ-016 Fetch: T0 asserts PCout, MARin, IncPC; T1 asserts read, MDRin; T2 asserts MDRout, IRin.
REQ-017 Execute states T3 onward SHALL be selected by opcode, and the last listed step SHALL return to T0.
REQ-018 R-type ALU, opcodes 5'h00-5'h0B: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,alu_op=opcode; T5 Zlowout,Gra,Rin.
REQ-019 Immediate ops (5'h0C addi, 5'h0D andi, 5'h0E ori): same as REQ-018 except T4 uses Cout in place of Grc,Rout, with alu_op 5'h00, 5'h02 and 5'h03 respectively.
REQ-020 mul 5'h0F / div 5'h10: T3 Gra,Rout,Yin; T4 Grb,Rout,Zin,alu_op=opcode; T5 Zlowout,LOin; T6 Zhighout,HIin.
REQ-021 neg 5'h11 / not 5'h12: T3 Grb,Rout,Zin,alu_op=opcode; T4 Zlowout,Gra,Rin.
REQ-022 Address phase for ld 5'h13, ldi 5'h14 and st 5'h15: T3 Grb,BAout,Yin; T4 Cout,Zin,alu_op=5'h00.
REQ-023 ld: T5 Zlowout,MARin; T6 read,MDRin; T7 MDRout,Gra,Rin.
REQ-024 ldi: T5 Zlowout,Gra,Rin.
REQ-025 st: T5 Zlowout,MARin; T6 Gra,Rout,MDRin (read=0); T7 write.
REQ-026 br 5'h16: T3 Gra,Rout,conIn; T4 PCout,Yin; T5 Cout,Zin,alu_op=5'h00; T6 Zlowout with PCin=con.
REQ-027 Branch not-taken (con=0 in T6) SHALL still spend T6 and SHALL leave PC unchanged.
REQ-028 jr 5'h17: T3 Gra,Rout,PCin.
REQ-029 jal 5'h18: T3 PCout,R8_RAin; T4 Gra,Rout,PCin.
REQ-030 in 5'h19: T3 InPortout,Gra,Rin.
REQ-031 out 5'h1A: T3 Gra,Rout,Out_portIn.
REQ-032 mfhi 5'h1B: T3 HIout,Gra,Rin.
REQ-033 mflo 5'h1C: T3 LOout,Gra,Rin.
REQ-034 nop 5'h1D: T2 SHALL go directly to T0.
REQ-035 halt 5'h1E SHALL go from T2 to HALT.
REQ-036 Opcode 5'h1F SHALL go to HALT if ILLEGAL_HALT=1 and to T0 otherwise.
REQ-037 HALT SHALL be absorbing, with all controls 0 and run=0; only clear exits it.
REQ-038 read and write SHALL never be asserted in the same cycle.
REQ-039 PCin and IncPC SHALL never be asserted in the same cycle.
REQ-040 ir SHALL be sampled combinationally in T3-T7, and the block SHALL require ir to be stable from T3 until the return to T0.

Reset
REQ-041 clear=0 SHALL force state RST immediately, asynchronously, including mid-instruction and mid-store.
REQ-042 In RST all outputs SHALL be 0 (write=0 guaranteed) and run=0.
REQ-043 On the first rising clock edge with clear=1, the FSM SHALL move RST to T0, and run SHALL be 1 from T0.

Verification
REQ-044 Reset: clear=0 for 3 cycles, then released -> cycle 1 all outputs 0 and run=0; cycle 2 PCout=MARin=IncPC=1.
REQ-045 add, ir=32'h0091_8000 (opcode 00): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,alu_op=00; T5 Gra,Rin; next fetch after 6 cycles.
REQ-046 ld, opcode 5'h13: 8-cycle instruction with read=1 in T1 and T6, MARin in T0 and T5, Gra,Rin in T7; write stays 0.
REQ-047 br (opcode 5'h16): con=1 -> PCin=1 in T6; con=0 -> PCin=0 in T6; both return to T0 after T6.
REQ-048 jal then halt: T3 R8_RAin with PCout, T4 PCin; next instruction opcode 5'h1E -> HALT with run=0 for 20 cycles despite clock.
REQ-049 Reset during st in T7 (write=1): clear=0 -> write drops to 0 in the same cycle without a clock edge; after release the FSM refetches from T0.
